// File: rtl/contact_impulse_accumulator.sv
// Per-body impulse/nudge/rotation delta accumulator with an ascending-index drain on frame commit.
// Optional IMPULSE_SAT_EN: saturating accumulation plus a sticky sat_flag output.
module contact_impulse_accumulator #(
    parameter int NUM_BODIES = 8,
    parameter int ID_W       = $clog2(NUM_BODIES)
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [ID_W-1:0] in_body_a,
    input  logic [ID_W-1:0] in_body_b,
    input  logic [31:0]     in_impulse_x,
    input  logic [31:0]     in_impulse_y,
    input  logic [31:0]     in_nudge_x,
    input  logic [31:0]     in_nudge_y,
    input  logic [10:0]     in_rot_impulse,
    input  logic            frame_commit,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ID_W-1:0] out_body,
    output logic [31:0]     out_dvel_x,
    output logic [31:0]     out_dvel_y,
    output logic [31:0]     out_dpos_x,
    output logic [31:0]     out_dpos_y,
    output logic [10:0]     out_domega,
    output logic            drain_done,
    output logic            self_contact_err
`ifdef IMPULSE_SAT_EN
    ,
    output logic            sat_flag
`endif
);

    typedef enum logic {ACCUM, DRAIN} state_t;

    typedef struct packed {
        logic [31:0] dvel_x;
        logic [31:0] dvel_y;
        logic [31:0] dpos_x;
        logic [31:0] dpos_y;
        logic [10:0] domega;
    } delta_t;

    function automatic logic [31:0] acc32(input logic [31:0] acc, input logic [31:0] d,
                                          input logic sub);
`ifdef IMPULSE_SAT_EN
        logic [32:0] s;
        s = sub ? ({acc[31], acc} - {d[31], d}) : ({acc[31], acc} + {d[31], d});
        if (s[32] != s[31]) return s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        return s[31:0];
`else
        return sub ? (acc - d) : (acc + d);
`endif
    endfunction

    function automatic logic [10:0] acc11(input logic [10:0] acc, input logic [10:0] d,
                                          input logic sub);
`ifdef IMPULSE_SAT_EN
        logic [11:0] s;
        s = sub ? ({acc[10], acc} - {d[10], d}) : ({acc[10], acc} + {d[10], d});
        if (s[11] != s[10]) return s[11] ? 11'h400 : 11'h3FF;
        return s[10:0];
`else
        return sub ? (acc - d) : (acc + d);
`endif
    endfunction

    function automatic delta_t apply(input delta_t acc, input delta_t d, input logic sub);
        delta_t r;
        r.dvel_x = acc32(acc.dvel_x, d.dvel_x, sub);
        r.dvel_y = acc32(acc.dvel_y, d.dvel_y, sub);
        r.dpos_x = acc32(acc.dpos_x, d.dpos_x, sub);
        r.dpos_y = acc32(acc.dpos_y, d.dpos_y, sub);
        r.domega = acc11(acc.domega, d.domega, sub);
        return r;
    endfunction

`ifdef IMPULSE_SAT_EN
    function automatic logic ovf32(input logic [31:0] acc, input logic [31:0] d, input logic sub);
        logic [32:0] s;
        s = sub ? ({acc[31], acc} - {d[31], d}) : ({acc[31], acc} + {d[31], d});
        return s[32] != s[31];
    endfunction

    function automatic logic ovf11(input logic [10:0] acc, input logic [10:0] d, input logic sub);
        logic [11:0] s;
        s = sub ? ({acc[10], acc} - {d[10], d}) : ({acc[10], acc} + {d[10], d});
        return s[11] != s[10];
    endfunction

    function automatic logic ovf(input delta_t acc, input delta_t d, input logic sub);
        return ovf32(acc.dvel_x, d.dvel_x, sub) || ovf32(acc.dvel_y, d.dvel_y, sub) ||
               ovf32(acc.dpos_x, d.dpos_x, sub) || ovf32(acc.dpos_y, d.dpos_y, sub) ||
               ovf11(acc.domega, d.domega, sub);
    endfunction
`endif

    state_t                state, state_next;
    delta_t                acc [NUM_BODIES];
    logic [NUM_BODIES-1:0] touched;
    delta_t                out_rec;
    delta_t                in_delta;
    delta_t                sum_a, sum_b;
    logic                  accept, pair, self_hit, handshake, load;
    logic [NUM_BODIES-1:0] cand;
    logic                  pick_any;
    logic [ID_W-1:0]       pick_idx;

    assign in_delta  = '{in_impulse_x, in_impulse_y, in_nudge_x, in_nudge_y, in_rot_impulse};
    assign accept    = in_valid && in_ready;
    assign pair      = accept && (in_body_a != in_body_b);
    assign self_hit  = accept && (in_body_a == in_body_b);
    assign handshake = out_valid && out_ready;
    // A new record is loaded on the first DRAIN cycle and after every handshake.
    assign load      = (state == DRAIN) && (!out_valid || handshake);
    assign sum_a     = apply(acc[in_body_a], in_delta, 1'b0);
    assign sum_b     = apply(acc[in_body_b], in_delta, 1'b1);

    assign out_dvel_x = out_rec.dvel_x;
    assign out_dvel_y = out_rec.dvel_y;
    assign out_dpos_x = out_rec.dpos_x;
    assign out_dpos_y = out_rec.dpos_y;
    assign out_domega = out_rec.domega;

    // Lowest touched body, skipping the one being retired this cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        cand     = touched;
        pick_any = 1'b0;
        pick_idx = '0;
        if (handshake) cand[out_body] = 1'b0;
        for (int i = NUM_BODIES - 1; i >= 0; i--) begin
            if (cand[i]) begin
                pick_any = 1'b1;
                pick_idx = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (frame_commit) state_next = DRAIN;
            end
            DRAIN: begin
                if (load && !pick_any) state_next = ACCUM;
            end
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) state <= ACCUM;
        else       state <= state_next;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            // NOTE: the accumulator array is reset explicitly; each frame must start from zero deltas.
            for (int i = 0; i < NUM_BODIES; i++) acc[i] <= '0;
            touched <= '0;
        end else begin
            for (int i = 0; i < NUM_BODIES; i++) begin
                if (pair && in_body_a == ID_W'(i)) begin
                    acc[i]     <= sum_a;
                    touched[i] <= 1'b1;
                end else if (pair && in_body_b == ID_W'(i)) begin
                    acc[i]     <= sum_b;
                    touched[i] <= 1'b1;
                end else if (handshake && out_body == ID_W'(i)) begin
                    acc[i]     <= '0;
                    touched[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            out_valid        <= 1'b0;
            out_body         <= '0;
            out_rec          <= '0;
            drain_done       <= 1'b0;
            self_contact_err <= 1'b0;
        end else begin
            self_contact_err <= self_hit;
            drain_done       <= load && !pick_any;
            if (load) begin
                out_valid <= pick_any;
                if (pick_any) begin
                    out_body <= pick_idx;
                    out_rec  <= acc[pick_idx];
                end
            end
        end
    end

`ifdef IMPULSE_SAT_EN
    always_ff @(posedge Clk) begin
        if (Reset) sat_flag <= 1'b0;
        else       sat_flag <= (sat_flag && !drain_done) ||
                               (pair && (ovf(acc[in_body_a], in_delta, 1'b0) ||
                                         ovf(acc[in_body_b], in_delta, 1'b1)));
    end
`endif

endmodule
